// File: rtl/controller.sv
`default_nettype none
// ============================================================================
// controller : multicycle RV32 subset control FSM (optional lui via CTRL_LUI_EN)
// Revision   : 1.0
// ============================================================================
module controller #(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       Halted
);

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_itype = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  typedef struct packed {
    logic       adrsrc;
    logic       memwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       halted;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam state_t c_trap_state = TRAP_ILLEGAL ? S_HALT : S_FETCH;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
    logic [2:0] a;
    a = c_alu_add;
    case (f3)
      3'b000:  a = sub ? c_alu_sub : c_alu_add;
      3'b010:  a = c_alu_slt;
      3'b110:  a = c_alu_or;
      3'b111:  a = c_alu_and;
      default: a = c_alu_add;
    endcase
    return a;
  endfunction

  // Select/enable pattern presented while sitting in state s.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [2:0] f3, input logic f7b5);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb   = 2'd2;
        c.resultsrc = 2'd2;
      end
      S_DECODE: begin
        c.alusrca = 2'd1;
        c.alusrcb = 2'd1;
      end
      S_MEMADR: begin
        c.alusrca = 2'd2;
        c.alusrcb = 2'd1;
      end
      S_MEMREAD: c.adrsrc = 1'b1;
      S_MEMWB: begin
        c.resultsrc = 2'd1;
        c.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECR: begin
        c.alusrca    = 2'd2;
        c.alucontrol = alu_decode(f3, f7b5);
      end
      S_EXECI: begin
        c.alusrca    = 2'd2;
        c.alusrcb    = 2'd1;
        c.alucontrol = alu_decode(f3, 1'b0);
      end
      S_ALUWB: c.regwrite = 1'b1;
      S_BRANCH: begin
        c.alusrca    = 2'd2;
        c.alucontrol = c_alu_sub;
      end
      S_JALR: begin
        c.alusrca = 2'd2;
        c.alusrcb = 2'd1;
      end
      S_JAL: begin
        c.alusrca = 2'd1;
        c.alusrcb = 2'd2;
        c.pcwrite = 1'b1;
      end
      S_LUI: begin
`ifdef CTRL_LUI_EN
        c.resultsrc = 2'd3;
        c.regwrite  = 1'b1;
`endif
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctl;
  logic   w_taken;
  logic   w_in_fetch;
  logic   w_in_branch;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          c_op_load, c_op_store: w_next = S_MEMADR;
          c_op_rtype:  w_next = f3_legal(funct3) ? S_EXECR : c_trap_state;
          c_op_itype:  w_next = f3_legal(funct3) ? S_EXECI : c_trap_state;
          c_op_branch: w_next = S_BRANCH;
          c_op_jal:    w_next = S_JAL;
          c_op_jalr:   w_next = S_JALR;
          c_op_lui: begin
`ifdef CTRL_LUI_EN
            w_next = S_LUI;
`else
            w_next = c_trap_state;
`endif
          end
          default: w_next = c_trap_state;
        endcase
      end
      S_MEMADR:   w_next = (op == c_op_load) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JALR:     w_next = S_JAL;
      S_JAL:      w_next = S_ALUWB;
      S_LUI:      w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free in each state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ctl   <= ctrl_for(S_FETCH, 3'b000, 1'b0);
    end else begin
      r_state <= w_next;
      r_ctl   <= ctrl_for(w_next, funct3, funct7b5);
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero[0];
      3'b001:  w_taken = ~Zero[0];
      3'b100:  w_taken = Zero[1];
      3'b101:  w_taken = ~Zero[1];
      default: w_taken = 1'b0;
    endcase
  end

  assign w_in_fetch  = (r_state == S_FETCH);
  assign w_in_branch = (r_state == S_BRANCH);

  // MemReady/Zero-dependent enables are combinational, so gate them with reset too.
  assign PCWrite    = reset & (r_ctl.pcwrite | (w_in_fetch & MemReady) | (w_in_branch & w_taken));
  assign IRWrite    = reset & w_in_fetch & MemReady;
  assign MemWrite   = r_ctl.memwrite;
  assign RegWrite   = r_ctl.regwrite;
  assign AdrSrc     = r_ctl.adrsrc;
  assign ResultSrc  = r_ctl.resultsrc;
  assign ALUSrcA    = r_ctl.alusrca;
  assign ALUSrcB    = r_ctl.alusrcb;
  assign ALUControl = r_ctl.alucontrol;
  assign Halted     = r_ctl.halted;

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      c_op_store:  ImmSrc = 3'b001;
      c_op_branch: ImmSrc = 3'b010;
      c_op_jal:    ImmSrc = 3'b011;
      c_op_lui:    ImmSrc = 3'b100;
      default:     ImmSrc = 3'b000;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 TRAP_ILLEGAL, 1, 1: an unsupported op/funct3 enters HALT; 0: it is treated as a NOP (DECODE -> FETCH).
REQ-002 clk  input  1  rising-edge clock; reset  input  1  asynchronous, active-low reset.
REQ-003 op  input  7  Instr[6:0]; funct3  input  3  Instr[14:12]; funct7b5  input  1  Instr[30].
REQ-004 Zero  input  2  ALU flags: [0]=operands equal, [1]=signed less-than.
REQ-005 MemReady  input  1  memory completes the current access this cycle.
REQ-006 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables/selects.
REQ-007 ResultSrc, ALUSrcA, ALUSrcB  output  2 each; ALUControl  output  3; ImmSrc  output  3.
REQ-008 Halted  output  1  high while in HALT.

Function
REQ-009 Encodings SHALL be: AdrSrc 0=PC, 1=Result; ALUSrcA 0=PC, 1=OldPC, 2=A; ALUSrcB 0=rs2, 1=Imm, 2=4; ResultSrc 0=ALUOut, 1=Data, 2=ALUResult, 3=ImmExt.
REQ-010 ALUControl SHALL be 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 ImmSrc SHALL be combinational from op: I(lw/I-type/jalr)=000, S=001, B=010, J=011, U=100, else 000.
REQ-012 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JALR, JAL, LUI, HALT.
REQ-013 FETCH: AdrSrc=0, ALUSrcA=0, ALUSrcB=2, add, ResultSrc=2; IRWrite=PCWrite=MemReady; stays in FETCH until MemReady, then DECODE.
REQ-014 DECODE: ALUSrcA=1, ALUSrcB=1, add (branch/jal target into ALUOut); next state by op: lw/sw->MEMADR, R->EXECR, I->EXECI, B->BRANCH, jal->JAL, jalr->JALR, lui->LUI.
REQ-015 MEMADR: ALUSrcA=2, ALUSrcB=1, add; lw->MEMREAD, sw->MEMWRITE.
REQ-016 MEMREAD: AdrSrc=1, ResultSrc=0; waits for MemReady, then MEMWB; MEMWB: ResultSrc=1, RegWrite=1, ->FETCH.
REQ-017 MEMWRITE: AdrSrc=1, ResultSrc=0, MemWrite=1 held until MemReady, then FETCH.
REQ-018 EXECR: ALUSrcA=2, ALUSrcB=0; funct3 000->add (sub if funct7b5), 010->slt, 110->or, 111->and; ->ALUWB.
REQ-019 EXECI: ALUSrcA=2, ALUSrcB=1; same funct3 map, 000 always add; ->ALUWB. ALUWB: ResultSrc=0, RegWrite=1, ->FETCH.
REQ-020 BRANCH: ALUSrcA=2, ALUSrcB=0, sub, ResultSrc=0; PCWrite=1 iff beq&Zero[0], bne&!Zero[0], blt&Zero[1], bge&!Zero[1]; ->FETCH.
REQ-021 JALR: ALUSrcA=2, ALUSrcB=1, add, ->JAL; JAL: ALUSrcA=1, ALUSrcB=2, add, ResultSrc=0, PCWrite=1, ->ALUWB.
REQ-022 LUI: ResultSrc=3, RegWrite=1, ->FETCH.
REQ-023 Unsupported op or R/I funct3 SHALL follow TRAP_ILLEGAL; HALT is absorbing, all enables 0.
REQ-024 In every state, enables not listed SHALL be 0; unlisted selects SHALL be 0.

Reset
REQ-025 reset low SHALL asynchronously force state FETCH and PCWrite, IRWrite, MemWrite, RegWrite, Halted to 0 regardless of MemReady.
REQ-026 Deassertion mid-instruction SHALL restart at FETCH; no partial write SHALL complete.

Configuration
REQ-027 With CTRL_LUI_EN defined, lui SHALL decode to LUI; without it, lui SHALL be unsupported per REQ-023 and ResultSrc never equals 3.

Verification
REQ-028 Reset low mid-MEMWRITE -> MemWrite drops same cycle; after release, FETCH with IRWrite=0 until MemReady.
REQ-029 add x3,x1,x2 (funct7b5=0), MemReady=1 -> FETCH,DECODE,EXECR(ALUControl=000),ALUWB(RegWrite=1); 4 cycles.
REQ-030 lw with MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, AdrSrc=1, then MEMWB RegWrite=1, ResultSrc=1.
REQ-031 bne with Zero=2'b01 -> PCWrite=0 in BRANCH; Zero=2'b00 -> PCWrite=1; bge Zero=2'b10 -> PCWrite=0.
REQ-032 jalr -> JALR, JAL(PCWrite=1, ResultSrc=0), ALUWB(RegWrite=1); op=7'b1111111 with TRAP_ILLEGAL=1 -> HALT, Halted=1 permanently.
REQ-033 lui with CTRL_LUI_EN -> LUI ResultSrc=3, RegWrite=1, ImmSrc=100; without it -> HALT.
